// File: rtl/mod_counter_if.sv
// mod_counter_if -- signal bundle for the general-purpose counter.
//
// Optional feature macro: COUNTER_PRESCALER_EN (adds the prescale field).
//
// Parameters:
//   counter_size  : width of count, modulo, compare and load values (>= 2)
//   prescale_size : width of the prescaler divisor (prescaler builds only)
//
// Signals (direction as seen from the counter, i.e. the slave modport):
//   enable, load, dir, mode, flag_clr : control inputs
//   cnt_in, modulo, cmp_val           : load / terminal / compare values
//   prescale                          : divisor minus 1 (prescaler builds)
//   cnt_out                           : registered count
//   overflow, underflow               : registered one-cycle event pulses
//   sticky                            : event flag, held until flag_clr
//   match                             : combinational cnt_out == cmp_val
interface mod_counter_if #(
  parameter int counter_size  = 8,
  parameter int prescale_size = 4
);

  logic                     enable;
  logic                     load;
  logic                     dir;
  logic                     mode;
  logic                     flag_clr;
  logic [counter_size-1:0]  cnt_in;
  logic [counter_size-1:0]  modulo;
  logic [counter_size-1:0]  cmp_val;
`ifdef COUNTER_PRESCALER_EN
  logic [prescale_size-1:0] prescale;
`endif
  logic [counter_size-1:0]  cnt_out;
  logic                     overflow;
  logic                     underflow;
  logic                     sticky;
  logic                     match;

  // Elaboration-time guard on the widths.
  if (counter_size < 2 || prescale_size < 1) begin : g_bad_width
    $error("mod_counter_if: counter_size must be >= 2 and prescale_size >= 1");
  end

  modport master (
`ifdef COUNTER_PRESCALER_EN
    output prescale,
`endif
    output enable, load, dir, mode, flag_clr, cnt_in, modulo, cmp_val,
    input  cnt_out, overflow, underflow, sticky, match
  );

  modport slave (
`ifdef COUNTER_PRESCALER_EN
    input  prescale,
`endif
    input  enable, load, dir, mode, flag_clr, cnt_in, modulo, cmp_val,
    output cnt_out, overflow, underflow, sticky, match
  );

endinterface

// File: rtl/mod_counter.sv
// mod_counter -- up/down counter with programmable terminal value, wrap or
// saturate mode, overflow/underflow pulses, sticky event flag and compare.
//
// Optional feature macro: COUNTER_PRESCALER_EN (step only on prescaler tick).
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   res_n : synchronous active-low reset
//   bus   : mod_counter_if.slave bundle (controls in, count/flags out)
//
// Count range is 0..modulo. A count loaded above modulo is treated as out of
// range: the next up step overflows, the next down step snaps to modulo.
module mod_counter #(
  parameter int counter_size  = 8,
  parameter int prescale_size = 4
) (
  input  logic         clk,
  input  logic         res_n,
  mod_counter_if.slave bus
);

  logic [counter_size-1:0] cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    sticky_q, sticky_d;
  logic                    tick;

  if (counter_size < 2 || prescale_size < 1) begin : g_bad_width
    $error("mod_counter: counter_size must be >= 2 and prescale_size >= 1");
  end

`ifdef COUNTER_PRESCALER_EN
  logic [prescale_size-1:0] psc_q, psc_d;

  // Prescaler advances only on enabled non-load cycles; load restarts phase.
  always_comb begin
    psc_d = psc_q;
    tick  = 1'b0;
    if (bus.load) begin
      psc_d = '0;
    end else if (bus.enable) begin
      if (psc_q == bus.prescale) begin
        psc_d = '0;
        tick  = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) psc_q <= '0;
    else        psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (bus.load) begin
      cnt_d = bus.cnt_in;
    end else if (bus.enable && tick) begin
      if (!bus.dir) begin
        if (cnt_q < bus.modulo) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
          cnt_d = bus.mode ? bus.modulo : '0;
        end
      end else begin
        if (cnt_q > bus.modulo) begin
          cnt_d = bus.modulo;
        end else if (cnt_q == '0) begin
          unf_d = 1'b1;
          cnt_d = bus.mode ? '0 : bus.modulo;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
    // An event in the same cycle as a clear keeps the flag set.
    if (ovf_d || unf_d) sticky_d = 1'b1;
    else if (bus.flag_clr) sticky_d = 1'b0;
    else sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.cnt_out   = cnt_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.sticky    = sticky_q;
  assign bus.match     = (cnt_q == bus.cmp_val);

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  logic clk;
  logic res_n;
  int   errors;
  int   checks;
  int   cyc;

  mod_counter_if #(.counter_size(8), .prescale_size(4)) bus ();

  mod_counter #(.counter_size(8), .prescale_size(4)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    cyc++;
    $display("[%0d] %s cnt=%0d ovf=%0b unf=%0b sticky=%0b match=%0b",
             cyc, tag, bus.cnt_out, bus.overflow, bus.underflow,
             bus.sticky, bus.match);
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    bus.enable = 1'b1; bus.load = 1'b1; bus.cnt_in = 8'd55;
    step("reset");
    step("reset");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.overflow !== 1'b0 ||
        bus.underflow !== 1'b0 || bus.sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt=%0d ovf=%0b unf=%0b sticky=%0b, required 0/0/0/0",
               bus.cnt_out, bus.overflow, bus.underflow, bus.sticky);
    end
    bus.load = 1'b0; bus.enable = 1'b0;
    res_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    int exp_c [7] = '{1, 2, 3, 4, 5, 0, 1};
    bus.modulo = 8'd5; bus.dir = 1'b0; bus.mode = 1'b0;
    bus.cmp_val = 8'd3; bus.enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step("up_wrap");
      checks++;
      if (bus.cnt_out !== exp_c[i][7:0] || bus.overflow !== (i == 5) ||
          bus.underflow !== 1'b0 || bus.match !== (exp_c[i] == 3)) begin
        errors++;
        $display("FAIL up_wrap[%0d]: cnt=%0d ovf=%0b unf=%0b match=%0b, required cnt=%0d ovf=%0b unf=0 match=%0b",
                 i, bus.cnt_out, bus.overflow, bus.underflow, bus.match,
                 exp_c[i], (i == 5), (exp_c[i] == 3));
      end
    end
    checks++;
    if (bus.sticky !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_sticky: sticky=%0b, required 1", bus.sticky);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_hold();
    step("hold");
    checks++;
    if (bus.cnt_out !== 8'd1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL hold: cnt=%0d ovf=%0b unf=%0b, required 1/0/0",
               bus.cnt_out, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_down_saturate();
    int exp_c [4] = '{1, 0, 0, 0};
    bus.modulo = 8'd9; bus.load = 1'b1; bus.cnt_in = 8'd2;
    step("load2");
    checks++;
    if (bus.cnt_out !== 8'd2 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL load2: cnt=%0d ovf=%0b unf=%0b, required 2/0/0",
               bus.cnt_out, bus.overflow, bus.underflow);
    end
    bus.load = 1'b0; bus.enable = 1'b1; bus.dir = 1'b1; bus.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("down_sat");
      checks++;
      if (bus.cnt_out !== exp_c[i][7:0] || bus.underflow !== (i >= 2) ||
          bus.overflow !== 1'b0) begin
        errors++;
        $display("FAIL down_sat[%0d]: cnt=%0d unf=%0b ovf=%0b, required cnt=%0d unf=%0b ovf=0",
                 i, bus.cnt_out, bus.underflow, bus.overflow, exp_c[i], (i >= 2));
      end
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_out_of_range();
    bus.modulo = 8'd10; bus.mode = 1'b0; bus.dir = 1'b0;
    bus.load = 1'b1; bus.cnt_in = 8'd200;
    step("load200");
    bus.load = 1'b0; bus.enable = 1'b1;
    step("oor_up");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL oor_up: cnt=%0d ovf=%0b, required 0/1", bus.cnt_out, bus.overflow);
    end
    bus.enable = 1'b0; bus.load = 1'b1;
    step("reload200");
    bus.load = 1'b0; bus.enable = 1'b1; bus.dir = 1'b1;
    step("oor_down");
    checks++;
    if (bus.cnt_out !== 8'd10 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL oor_down: cnt=%0d ovf=%0b unf=%0b, required 10/0/0",
               bus.cnt_out, bus.overflow, bus.underflow);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_sticky_clear();
    bus.modulo = 8'd3; bus.dir = 1'b0; bus.mode = 1'b0;
    bus.load = 1'b1; bus.cnt_in = 8'd3;
    step("load3");
    bus.load = 1'b0; bus.enable = 1'b1; bus.flag_clr = 1'b1;
    step("clr_collide");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.overflow !== 1'b1 || bus.sticky !== 1'b1) begin
      errors++;
      $display("FAIL clr_collide: cnt=%0d ovf=%0b sticky=%0b, required 0/1/1",
               bus.cnt_out, bus.overflow, bus.sticky);
    end
    bus.enable = 1'b0;
    step("clr");
    checks++;
    if (bus.sticky !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr: sticky=%0b ovf=%0b, required 0/0", bus.sticky, bus.overflow);
    end
    bus.flag_clr = 1'b0;
  endtask

  task automatic test_modulo_zero();
    bus.modulo = 8'd0; bus.load = 1'b1; bus.cnt_in = 8'd0;
    step("load0");
    bus.load = 1'b0; bus.enable = 1'b1; bus.dir = 1'b0;
    step("m0_up");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL m0_up: cnt=%0d ovf=%0b unf=%0b, required 0/1/0",
               bus.cnt_out, bus.overflow, bus.underflow);
    end
    bus.dir = 1'b1;
    step("m0_down");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b1) begin
      errors++;
      $display("FAIL m0_down: cnt=%0d ovf=%0b unf=%0b, required 0/0/1",
               bus.cnt_out, bus.overflow, bus.underflow);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_free_run();
    bus.modulo = 8'd255; bus.mode = 1'b0; bus.dir = 1'b0;
    bus.load = 1'b1; bus.cnt_in = 8'd254;
    step("load254");
    bus.load = 1'b0; bus.enable = 1'b1;
    step("fr_up1");
    checks++;
    if (bus.cnt_out !== 8'd255 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fr_up1: cnt=%0d ovf=%0b, required 255/0", bus.cnt_out, bus.overflow);
    end
    step("fr_up2");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL fr_up2: cnt=%0d ovf=%0b, required 0/1", bus.cnt_out, bus.overflow);
    end
    bus.dir = 1'b1;
    step("fr_down");
    checks++;
    if (bus.cnt_out !== 8'd255 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fr_down: cnt=%0d unf=%0b ovf=%0b, required 255/1/0",
               bus.cnt_out, bus.underflow, bus.overflow);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_modulo_shrink();
    bus.modulo = 8'd255; bus.dir = 1'b0; bus.mode = 1'b1;
    bus.load = 1'b1; bus.cnt_in = 8'd8;
    step("load8");
    bus.load = 1'b0; bus.enable = 1'b1; bus.modulo = 8'd4;
    step("shrink_up");
    checks++;
    if (bus.cnt_out !== 8'd4 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL shrink_up: cnt=%0d ovf=%0b, required 4/1 (saturate)",
               bus.cnt_out, bus.overflow);
    end
    bus.enable = 1'b0; bus.load = 1'b1;
    step("reload8");
    bus.load = 1'b0; bus.enable = 1'b1; bus.dir = 1'b1;
    step("shrink_down");
    checks++;
    if (bus.cnt_out !== 8'd4 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL shrink_down: cnt=%0d unf=%0b ovf=%0b, required 4/0/0",
               bus.cnt_out, bus.underflow, bus.overflow);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_mid_reset();
    bus.modulo = 8'd20; bus.dir = 1'b0; bus.enable = 1'b1;
    step("count");
    step("count");
    res_n = 1'b0; bus.load = 1'b1; bus.cnt_in = 8'd7;
    step("mid_reset");
    checks++;
    if (bus.cnt_out !== 8'd0 || bus.sticky !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d sticky=%0b ovf=%0b, required 0/0/0",
               bus.cnt_out, bus.sticky, bus.overflow);
    end
    res_n = 1'b1; bus.load = 1'b0; bus.enable = 1'b0;
  endtask

`ifdef COUNTER_PRESCALER_EN
  task automatic test_prescaler();
    int exp_a [7] = '{0, 0, 1, 1, 1, 2, 2};
    int exp_b [3] = '{3, 3, 4};
    bus.prescale = 4'd2; bus.modulo = 8'd255; bus.dir = 1'b0; bus.mode = 1'b0;
    bus.cmp_val = 8'd4; bus.load = 1'b1; bus.cnt_in = 8'd0;
    step("psc_load");
    bus.load = 1'b0; bus.enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step("psc_run");
      checks++;
      if (bus.cnt_out !== exp_a[i][7:0]) begin
        errors++;
        $display("FAIL psc_run[%0d]: cnt=%0d, required %0d", i, bus.cnt_out, exp_a[i]);
      end
    end
    bus.enable = 1'b0;
    step("psc_freeze");
    step("psc_freeze");
    bus.enable = 1'b1;
    step("psc_resume1");
    checks++;
    if (bus.cnt_out !== 8'd2) begin
      errors++;
      $display("FAIL psc_resume1: cnt=%0d, required 2", bus.cnt_out);
    end
    step("psc_resume2");
    checks++;
    if (bus.cnt_out !== 8'd3) begin
      errors++;
      $display("FAIL psc_resume2: cnt=%0d, required 3", bus.cnt_out);
    end
    // Load part-way into a phase; the phase must restart.
    step("psc_mid");
    bus.load = 1'b1; bus.cnt_in = 8'd3;
    step("psc_reload");
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("psc_after_load");
      checks++;
      if (bus.cnt_out !== exp_b[i][7:0] || bus.match !== (exp_b[i] == 4)) begin
        errors++;
        $display("FAIL psc_after_load[%0d]: cnt=%0d match=%0b, required %0d/%0b",
                 i, bus.cnt_out, bus.match, exp_b[i], (exp_b[i] == 4));
      end
    end
    bus.enable = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    res_n  = 1'b0;
    bus.enable = 1'b0; bus.load = 1'b0; bus.dir = 1'b0; bus.mode = 1'b0;
    bus.flag_clr = 1'b0; bus.cnt_in = '0; bus.modulo = '0; bus.cmp_val = '0;
`ifdef COUNTER_PRESCALER_EN
    bus.prescale = '0;
`endif
    test_reset();
    test_up_wrap();
    test_hold();
    test_down_saturate();
    test_out_of_range();
    test_sticky_clear();
    test_modulo_zero();
    test_free_run();
    test_modulo_shrink();
    test_mid_reset();
`ifdef COUNTER_PRESCALER_EN
    test_prescaler();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
